// File: rtl/lz_decomp_pkg.sv
// Shared types and defaults for the LZ stream decompressor.
// Holds the FSM state encoding, default field widths and the default length bias.
package lz_decomp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLit,
        StCpRd,
        StCpOut
    } state_e;

    localparam int unsigned DEFAULT_LEN_BIAS = 3;
    localparam int unsigned DEFAULT_LEN_W    = 4;
    localparam int unsigned DEFAULT_OFFSET_W = 12;

    // Copy token layout at the default widths; the top re-declares it at its own widths.
    typedef struct packed {
        logic [DEFAULT_LEN_W-1:0]    length;
        logic [DEFAULT_OFFSET_W-1:0] offset;
    } token_default_t;

endpackage

// File: rtl/lz_history_ram.sv
// Circular history store: one write port, one synchronous read port.
// Read data holds its value whenever rd_en is low.
module lz_history_ram #(
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/lz_stream_decompressor.sv
// LZRW1-style token decompressor with framing, overlap-safe copies and offset checking.
// One token in per handshake, one decoded byte out per handshake.
module lz_stream_decompressor
    import lz_decomp_pkg::*;
#(
    parameter int unsigned HISTORY_SIZE = 4096,
    parameter int unsigned OFFSET_W     = $clog2(HISTORY_SIZE),
    parameter int unsigned LEN_W        = 4,
    parameter int unsigned LEN_BIAS     = DEFAULT_LEN_BIAS
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_control,
    input  logic [LEN_W+OFFSET_W-1:0] in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [7:0]                out_byte,
    output logic                      out_last,
    output logic                      history_full,
    output logic                      error,
    output logic                      busy
);

    typedef struct packed {
        logic [LEN_W-1:0]    length;
        logic [OFFSET_W-1:0] offset;
    } token_t;

    localparam logic [OFFSET_W:0]   FILL_MAX = (OFFSET_W+1)'(HISTORY_SIZE);
    localparam logic [OFFSET_W-1:0] PTR_ONE  = OFFSET_W'(1);
    localparam logic [LEN_W:0]      REM_ONE  = (LEN_W+1)'(1);

    state_e              state_q, state_d;
    logic [OFFSET_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [OFFSET_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LEN_W:0]      remaining_q, remaining_d;
    logic [OFFSET_W:0]   fill_q, fill_d;
    logic [7:0]          lit_q, lit_d;
    logic                last_q, last_d;
    logic                error_q, error_d;

    token_t              tok;
    logic                accept;
    logic                out_fire;
    logic                copy_legal;
    logic [OFFSET_W:0]   fill_inc;
    logic [7:0]          ram_rdata;

    assign tok        = in_data;
    assign in_ready   = reset && (state_q == StIdle);
    assign accept     = in_valid && in_ready;
    assign out_valid  = reset && ((state_q == StLit) || (state_q == StCpOut));
    assign out_fire   = out_valid && out_ready;
    assign copy_legal = (tok.offset != '0) && ({1'b0, tok.offset} <= fill_q);
    assign fill_inc   = (fill_q == FILL_MAX) ? fill_q : fill_q + (OFFSET_W+1)'(1);

    assign out_last     = last_q && ((state_q == StLit) ||
                                     ((state_q == StCpOut) && (remaining_q == REM_ONE)));
    assign history_full = (fill_q == FILL_MAX);
    assign error        = error_q;
    assign busy         = (state_q != StIdle);

    always_comb begin
        out_byte = 8'h00;
        unique case (state_q)
            StLit:   out_byte = lit_q;
            StCpOut: out_byte = ram_rdata;
            default: out_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        remaining_d = remaining_q;
        fill_d      = fill_q;
        lit_d       = lit_q;
        last_d      = last_q;
        error_d     = error_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!in_control) begin
                        lit_d   = in_data[7:0];
                        last_d  = in_last;
                        state_d = StLit;
                    end else if (copy_legal) begin
                        rd_ptr_d    = wr_ptr_q - tok.offset;
                        remaining_d = (LEN_W+1)'(tok.length) + (LEN_W+1)'(LEN_BIAS);
                        last_d      = in_last;
                        state_d     = StCpRd;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            StLit: begin
                if (out_fire) begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    fill_d   = out_last ? '0 : fill_inc;
                    state_d  = StIdle;
                end
            end
            StCpRd: begin
                state_d = StCpOut;
            end
            StCpOut: begin
                if (out_fire) begin
                    wr_ptr_d    = wr_ptr_q + PTR_ONE;
                    rd_ptr_d    = rd_ptr_q + PTR_ONE;
                    remaining_d = remaining_q - REM_ONE;
                    fill_d      = out_last ? '0 : fill_inc;
                    // The write lands before the next CP_RD, so overlapping runs see fresh bytes.
                    state_d     = (remaining_q == REM_ONE) ? StIdle : StCpRd;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            remaining_q <= '0;
            fill_q      <= '0;
            lit_q       <= 8'h00;
            last_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            remaining_q <= remaining_d;
            fill_q      <= fill_d;
            lit_q       <= lit_d;
            last_q      <= last_d;
            error_q     <= error_d;
        end
    end

    lz_history_ram #(
        .DEPTH  (HISTORY_SIZE),
        .ADDR_W (OFFSET_W)
    ) u_history_ram (
        .clock   (clock),
        .wr_en   (out_fire),
        .wr_addr (wr_ptr_q),
        .wr_data (out_byte),
        .rd_en   (state_q == StCpRd),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rdata)
    );

endmodule

// File: doc/lz_stream_decompressor.md
# lz_stream_decompressor

Parametrised, stream-handshaked LZRW1-style decompressor. It accepts one token per transfer: either a literal byte or a (length, offset) copy into a circular history RAM. It emits decompressed bytes one per output transfer, with full valid/ready backpressure on both sides. Compared with the first-generation decompressor, it adds frame boundaries, overlap-safe copies, offset range checking and a sticky error flag. It sits between the compressed-stream parser and the byte sink.

## Interface
Parameters:
- HISTORY_SIZE, 4096, history depth in bytes; must be a power of 2.
- OFFSET_W, $clog2(HISTORY_SIZE), width of the copy offset field.
- LEN_W, 4, width of the copy length field.
- LEN_BIAS, 3, added to the length field to give the copy count (default range 3..18).

Ports:
- clock  input  1  single clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-low: state is cleared on a rising clock edge while reset==0.
- in_valid  input  1  a token is offered.
- in_ready  output  1  the block accepts the token this cycle.
- in_control  input  1  0 = literal, 1 = copy.
- in_data  input  LEN_W+OFFSET_W  for a literal: [7:0] is the byte. For a copy: {length, offset}, with length in the MSBs.
- in_last  input  1  this token ends the frame.
- out_valid  output  1  out_byte is valid.
- out_ready  input  1  the sink takes the byte.
- out_byte  output  8  decompressed byte.
- out_last  output  1  last byte of a frame.
- history_full  output  1  fill count == HISTORY_SIZE.
- error  output  1  sticky flag: an illegal copy was dropped.
- busy  output  1  state != IDLE.

## Operation
- Token handshake: a token is accepted when in_valid && in_ready. in_ready = (state==IDLE) && reset deasserted.
- Output handshake: a byte is transferred when out_valid && out_ready. While out_ready==0, out_byte and out_last hold stable.
- State registers:
  - wr_ptr[OFFSET_W-1:0], rd_ptr[OFFSET_W-1:0], remaining[LEN_W:0].
  - fill[OFFSET_W:0], which saturates at HISTORY_SIZE.
  - latched literal byte, last flag, error.
- States:
  - IDLE: on accepting a literal → LIT.
  - IDLE: on accepting a legal copy → set rd_ptr = wr_ptr − offset (mod HISTORY_SIZE) and remaining = length+LEN_BIAS, then → CP_RD.
  - IDLE: on an illegal copy (offset==0 or offset>fill) → set error=1, drop the token, produce no output, stay in IDLE.
  - LIT: out_valid=1 and out_byte = the latched byte. On the transfer: write the byte at wr_ptr, increment wr_ptr, fill++ (saturating), then → IDLE.
  - CP_RD: present rd_ptr to the RAM and set out_valid=0, then → CP_OUT.
  - CP_OUT: out_valid=1 and out_byte = RAM data. On the transfer: write the byte at wr_ptr, increment wr_ptr and rd_ptr, fill++, remaining--. If remaining reaches 0 → IDLE, otherwise → CP_RD.
- Overlapping copies (offset < count) must reproduce run-length behaviour. Each byte is written before the next read is issued, so no bypass is needed.
- Wrap-around: all pointer arithmetic is modulo HISTORY_SIZE with natural OFFSET_W-bit wrap.
- out_last = latched last flag && (state==LIT || (state==CP_OUT && remaining==1)).
- Frame end: after the transfer that carries out_last, set fill=0. wr_ptr is unchanged and old bytes become unreachable.
- Reset values:
  - State IDLE; wr_ptr, rd_ptr, remaining and fill = 0.
  - error=0, out_valid=0, out_byte=0, out_last=0, history_full=0, busy=0.
  - in_ready=0 while reset==0.
  - RAM contents are not cleared.
- Reset mid-token: the token is abandoned, no further output is produced, and error is cleared.

## Timing
- Literal: accepted at cycle t, out_valid=1 at t+1.
- Copy: accepted at t, first byte valid at t+2. With out_ready held at 1, each subsequent byte follows 2 cycles later, so a copy of N bytes completes at t+2N.
- Next token: in_ready returns to 1 in the cycle after the final output transfer.
- RAM: synchronous read, 1-cycle latency; write on the clock edge of the output transfer.
- history_full and error are registered and update the cycle after the causing event.

## Structure
- Package lz_decomp_pkg holds:
  - the state enum {IDLE, LIT, CP_RD, CP_OUT};
  - a parametrised-width token struct {length, offset};
  - the default LEN_BIAS.
- Sub-module lz_history_ram: simple dual-port RAM, HISTORY_SIZE×8, 1-cycle read, one write port.

## Test plan
- Literals 'A','B','C' with out_ready=1 → bytes 41,42,43 on consecutive outputs, each 1 cycle after acceptance. in_last on 'C' gives out_last on 43.
- Literals 'a','b', then copy length=0, offset=1 → output 61,62,62,62,62. The overlapping run reads back freshly written bytes.
- Write 4094 literals, then 3 literals crossing the wrap, then copy offset=4 length=1 → 4 bytes read across address 4095→0 match the originals, and history_full=1 after 4096 bytes.
- Copy with offset=5 after only 3 literals, and a copy with offset=0 → no output, error=1 stays sticky, and the next literal decodes normally.
- out_ready toggled randomly during an 18-byte copy → no bytes lost or duplicated, and out_byte is stable while stalled.
- reset=0 asserted in CP_OUT mid-copy → the next cycle has out_valid=0, busy=0, error=0 and fill=0. An offset=1 copy is then rejected with error=1.
